// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says player-input path.
//   colour_t          : 2-bit colour code, one named constant per switch
//   capture_state_t   : states of the input_capture FSM
//   DEFAULT_*         : default debounce / timeout periods at 50 MHz
//   encode_onehot()   : one-hot switch pattern -> colour code
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t COLOUR_GREEN  = 2'd0;   // sw[0]
    localparam colour_t COLOUR_RED    = 2'd1;   // sw[1]
    localparam colour_t COLOUR_YELLOW = 2'd2;   // sw[2]
    localparam colour_t COLOUR_BLUE   = 2'd3;   // sw[3]

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_HELD,
        ST_WAIT_RELEASE,
        ST_LOCKED
    } capture_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;      // 10 ms
    localparam int DEFAULT_TIMEOUT_CYCLES  = 250_000_000;  // 5 s
    localparam int TIMEOUT_W               = 28;

    // Only meaningful for one-hot patterns; callers qualify with $onehot.
    function automatic colour_t encode_onehot(input logic [3:0] pat);
        colour_t c;
        c = COLOUR_GREEN;
        if (pat[1]) c = COLOUR_RED;
        if (pat[2]) c = COLOUR_YELLOW;
        if (pat[3]) c = COLOUR_BLUE;
        return c;
    endfunction

endpackage

// File: rtl/debounce4.sv
// Four-channel switch conditioner: 2-flop synchroniser followed by a
// stability counter. The debounced pattern only changes once the synchronised
// pattern has held still for DEBOUNCE_CYCLES cycles.
//   clk, reset : clock, synchronous active-high reset
//   sw         : raw asynchronous switch levels
//   deb        : debounced switch pattern
module debounce4
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    output logic [3:0] deb
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cnt   <= '0;
            deb   <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            // sync1 is the next synchronised sample: a difference means the
            // pattern is changing at this edge, so stability restarts.
            if (sync1 != sync2) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Counter parks here; reloading the same pattern is harmless.
                deb <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_capture.sv
// Player-input front end for Simon Says. Debounces the four colour switches,
// turns a clean single press into a colour code plus one-cycle valid strobe,
// and flags multi-switch presses and response timeouts.
//   clk, reset   : clock, synchronous active-high reset
//   enable       : high during the player's turn (capture armed)
//   sw[3:0]      : raw switches, sw[n] = colour n
//   colour_o     : colour of the last accepted press, held until the next
//   valid_o      : one-cycle strobe, colour_o is new
//   multi_err_o  : one-cycle strobe, more than one switch pressed
//   timeout_o    : one-cycle strobe, no press within TIMEOUT_CYCLES
//   busy_o       : high in every state except IDLE and LOCKED
// Build option: define INPUT_TIMEOUT_EN to build the response timeout, its
// strobe and the LOCKED state. Without it WAIT_PRESS waits indefinitely and
// timeout_o is tied low.
module input_capture
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] sw,
    output logic [1:0] colour_o,
    output logic       valid_o,
    output logic       multi_err_o,
    output logic       timeout_o,
    output logic       busy_o
);

    logic [3:0]     deb;
    capture_state_t state;
    logic           deb_zero;
    logic           deb_onehot;
    logic           deb_multi;
    logic           held_changed;
    logic           tmo_hit;

    debounce4 #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .sw   (sw),
        .deb  (deb)
    );

    assign deb_zero     = (deb == 4'b0000);
    assign deb_onehot   = $onehot(deb);
    assign deb_multi    = !deb_zero && !deb_onehot;
    // In HELD, colour_o still names the switch that was accepted.
    assign held_changed = (deb != (4'b0001 << colour_o));

`ifdef INPUT_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] tcnt;

    // Held at zero outside WAIT_PRESS, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || state != ST_WAIT_PRESS) begin
            tcnt <= '0;
        end else if (tcnt != '1) begin
            tcnt <= tcnt + TIMEOUT_W'(1);
        end
    end

    assign tmo_hit = (state == ST_WAIT_PRESS) && (tcnt == TMO_LAST);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit            = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            colour_o    <= COLOUR_GREEN;
            valid_o     <= 1'b0;
            multi_err_o <= 1'b0;
            busy_o      <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
        end else begin
            valid_o     <= 1'b0;
            multi_err_o <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
            // Dropping enable overrides every transition and every strobe.
            if (!enable) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy_o <= 1'b1;
                        // A switch already down at arm time must be released
                        // before it can count as a press.
                        state  <= deb_zero ? ST_WAIT_PRESS : ST_WAIT_RELEASE;
                    end
                    ST_WAIT_PRESS: begin
                        if (deb_onehot) begin
                            colour_o <= encode_onehot(deb);
                            valid_o  <= 1'b1;
                            state    <= ST_HELD;
                        end else if (deb_multi) begin
                            multi_err_o <= 1'b1;
                            state       <= ST_WAIT_RELEASE;
`ifdef INPUT_TIMEOUT_EN
                        end else if (tmo_hit) begin
                            timeout_o <= 1'b1;
                            busy_o    <= 1'b0;
                            state     <= ST_LOCKED;
`endif
                        end
                    end
                    ST_HELD: begin
                        if (deb_zero) begin
                            state <= ST_WAIT_PRESS;
                        end else if (held_changed) begin
                            multi_err_o <= 1'b1;
                            state       <= ST_WAIT_RELEASE;
                        end
                    end
                    ST_WAIT_RELEASE: begin
                        if (deb_zero) begin
                            state <= ST_WAIT_PRESS;
                        end
                    end
                    ST_LOCKED: begin
                        // Sits here until enable drops.
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
